chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
Parameterised multi-cycle adder/subtractor, successor to the 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, over WIDTH/CHUNK cycles.
- Carry is held in a register between chunks.
- Valid/ready handshakes on input and output.
- Used where a full-width ripple chain would not meet timing, trading latency for a short carry path.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH. N = WIDTH/CHUNK is the number of chunk cycles.

Ports:
clk  input  1  single clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand request.
in_ready  output  1  block can accept an operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
s  output  WIDTH  result.
cout  output  1  carry out of MSB (sub mode: 1 = no borrow).
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset is asynchronous, active-high.
  - Asserting rst forces state IDLE, chunk counter 0, carry 0, internal operand/accumulator registers 0.
  - Outputs on reset: s=0, cout=0, ovf=0, out_valid=0, in_ready=1.
  - Reset mid-operation abandons the operation; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at a rising edge: latch a; latch b if sub=0, else ~b; carry <= cin ^ sub; counter <= 0; go to RUN.
  - Net arithmetic: sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, chunk k = counter is summed as A[k] + B'[k] + carry. The CHUNK-bit sum goes into accumulator slice k; carry <= chunk carry-out.
  - On the last chunk (counter = N-1), also record the carry into the MSB for ovf, then go to DONE.
  - Exactly N RUN cycles.
- DONE:
  - out_valid=1, in_ready=0.
  - s, cout, ovf are loaded from the accumulator on entry to DONE.
  - On out_ready=1 at an edge: go to IDLE; out_valid falls and in_ready rises the next cycle.
  - out_ready low holds DONE indefinitely with outputs stable.
- Latency:
  - Accept at edge E, out_valid=1 after edge E+N.
  - Earliest next accept is edge E+N+2, giving throughput of one op per N+2 cycles.
  - No overlap between operations.
- Result stability: s/cout/ovf change only on entry to DONE (or reset). They hold the last result through IDLE and RUN, and are never partially updated.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, in both modes.
- Input-side rules:
  - in_valid while in_ready=0 is ignored; operand changes during RUN have no effect.
  - out_ready while out_valid=0 is ignored.
- Degenerate configuration CHUNK=WIDTH (N=1): one RUN cycle, same FSM.
- Wrap-around: s is modulo 2^WIDTH; cout carries the overflow bit.

Test Plan:
1. Basic add, WIDTH=16/CHUNK=4: a=0x1234, b=0x0FCD, cin=0, sub=0 -> s=0x2201, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout RUN/DONE.
2. Full carry ripple across all chunks: a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, ovf=0. Separately a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
3. Subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0, ovf=0. With a=0x0007, b=0x0005, sub=1, cin=1 -> s=0x0001, cout=1.
4. Backpressure: after a result, hold out_ready=0 for 5 cycles while toggling in_valid with new operands -> out_valid, s, cout, ovf stay constant; in_ready stays 0; no new op is accepted. Raise out_ready -> IDLE next cycle, then accept.
5. Reset mid-RUN: assert rst asynchronously after 2 chunk cycles -> immediately out_valid=0, in_ready=1, s=0, cout=0, ovf=0. After release, a=0x0004, b=0x0008, cin=1 -> s=0x000D, cout=0.
6. Parameter sweep: repeat tests 1-3 with CHUNK=1, 8, 16 -> identical results; latency equals 16, 2, 1 cycles respectively. Randomised ops checked against a reference model.

Source files
------------

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock,
// with the carry held in a register between chunks and valid/ready handshakes.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] areg, breg, acc, acc_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0]   csum;
    logic             last, cin_msb;

    // Operands shift down one chunk per cycle while sums enter the accumulator
    // from the top, so after N cycles chunk k sits in slice k.
    always_comb begin
        ca      = areg[CHUNK-1:0];
        cb      = breg[CHUNK-1:0];
        csum    = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
        acc_nx  = acc >> CHUNK;
        acc_nx[WIDTH-1 -: CHUNK] = csum[CHUNK-1:0];
        cin_msb = ca[CHUNK-1] ^ cb[CHUNK-1] ^ csum[CHUNK-1];
        last    = (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg  <= '0;
            breg  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        areg  <= a;
                        breg  <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    areg  <= areg >> CHUNK;
                    breg  <= breg >> CHUNK;
                    acc   <= acc_nx;
                    carry <= csum[CHUNK];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        s    <= acc_nx;
                        cout <= csum[CHUNK];
                        ovf  <= cin_msb ^ csum[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: four instances (CHUNK=4,1,8,16) share
// the same stimulus; results, latency, backpressure and reset are checked.
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic [3:0]  ir, ov, co, of;
    logic [15:0] sv [4];

    int n_checks = 0;
    int n_fail   = 0;
    int lat_exp [4] = '{4, 16, 2, 1};

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
        .s(sv[0]), .cout(co[0]), .ovf(of[0]));
    chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
        .s(sv[1]), .cout(co[1]), .ovf(of[1]));
    chunked_serial_adder #(.WIDTH(16), .CHUNK(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
        .s(sv[2]), .cout(co[2]), .ovf(of[2]));
    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[3]), .out_ready(out_ready),
        .s(sv[3]), .cout(co[3]), .ovf(of[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_results(input string tag, input logic [15:0] es,
                                     input logic ec, input logic eo);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s_s%0d", tag, d), 32'(sv[d]), 32'(es));
            check($sformatf("%s_cout%0d", tag, d), 32'(co[d]), 32'(ec));
            check($sformatf("%s_ovf%0d", tag, d), 32'(of[d]), 32'(eo));
        end
    endtask

    // Accept one op on all instances and wait (bounded) for every result.
    task automatic start_and_wait(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                                  input logic tc, input logic tsub);
        int lat [4];
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(ir), 32'h0);
        lat = '{0, 0, 0, 0};
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++)
                if (ov[d] && lat[d] == 0) lat[d] = cyc;
            if (ov == 4'hF) break;
        end
        for (int d = 0; d < 4; d++)
            check($sformatf("%s_lat%0d", tag, d), 32'(lat[d]), 32'(lat_exp[d]));
        check({tag, "_inready_done"}, 32'(ir), 32'h0);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_ir"}, 32'(ir), 32'hF);
        check({tag, "_idle_ov"}, 32'(ov), 32'h0);
    endtask

    task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tc, input logic tsub,
                      input logic [15:0] es, input logic ec, input logic eo);
        start_and_wait(tag, ta, tb, tc, tsub);
        check_all_results(tag, es, ec, eo);
        release_result(tag);
    endtask

    initial begin
        logic [15:0] ra, rb, bb, ms;
        logic        rc, rs, mc, mo;
        logic [16:0] full;

        #2;
        check("rst_ir", 32'(ir), 32'hF);
        check("rst_ov", 32'(ov), 32'h0);
        check_all_results("rst", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        op("add",      16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        op("ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op("sub",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op("subb",     16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        op("subovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: result must hold and new requests must be ignored.
        start_and_wait("bp", 16'h00F0, 16'h0F0F, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = 16'h1111 * 16'(i + 1); b = 16'hFFFF; cin = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp_ov%0d", i), 32'(ov), 32'hF);
            check($sformatf("bp_ir%0d", i), 32'(ir), 32'h0);
            check_all_results($sformatf("bp%0d", i), 16'h0FFF, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        release_result("bp");
        op("after_bp", 16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);

        // Asynchronous reset two edges into an operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mrst_ir", 32'(ir), 32'hF);
        check("mrst_ov", 32'(ov), 32'h0);
        check_all_results("mrst", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        op("post_rst", 16'h0004, 16'h0008, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            bb   = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + {16'h0, rc ^ rs};
            ms   = full[15:0];
            mc   = full[16];
            mo   = (ra[15] == bb[15]) && (ms[15] != ra[15]);
            op($sformatf("rnd%0d", i), ra, rb, rc, rs, ms, mc, mo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
